// File: rtl/dred_pkg.sv
// Shared constants and types for the D-reduced function expander.
package dred_pkg;

  localparam int unsigned N_IN  = 24;
  localparam int unsigned K     = 4;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned LUT_W = 1 << K;

  typedef enum logic [2:0] {
    CFG_LUT      = 3'd0,
    CFG_SEL      = 3'd1,
    CFG_CHI_MASK = 3'd2,
    CFG_CHI_VAL  = 3'd3,
    CFG_FB       = 3'd4
  } cfg_addr_e;

  typedef logic [K-1:0][IDX_W-1:0] sel_vec_t;

  // Indices at or beyond N_IN shift the vector out entirely and read 0.
  function automatic logic pick_bit(logic [N_IN-1:0] x, logic [IDX_W-1:0] idx);
    logic [N_IN-1:0] sh;
    sh = x >> idx;
    return sh[0];
  endfunction

endpackage

// File: rtl/dred_proj_expander_if.sv
// Config, input-vector and result handshake bundle of the expander.
interface dred_proj_expander_if;
  import dred_pkg::*;

  logic            cfg_we;
  logic            cfg_ready;
  logic [2:0]      cfg_addr;
  logic [N_IN-1:0] cfg_wdata;
  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_x;
  logic            out_valid;
  logic            out_ready;
  logic            out_y;
  logic            out_in_proj;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, in_valid, in_x, out_ready,
    input  cfg_ready, in_ready, out_valid, out_y, out_in_proj
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_x, out_ready,
    output cfg_ready, in_ready, out_valid, out_y, out_in_proj
  );

endinterface

// File: rtl/dred_lut_eval.sv
// Combinational reconstruction: gather K selected bits, read the LUT, or fall back.
module dred_lut_eval
  import dred_pkg::*;
(
  input  logic [N_IN-1:0]  x_i,
  input  logic             chi_i,
  input  logic [LUT_W-1:0] lut_i,
  input  sel_vec_t         sel_i,
  input  logic [IDX_W-1:0] fb_idx_i,
  input  logic             fb_inv_i,
  output logic             y_o
);

  logic [K-1:0] addr;

  always_comb begin
    addr = '0;
    for (int unsigned j = 0; j < K; j++) begin
      addr[j] = pick_bit(x_i, sel_i[j]);
    end
  end

  assign y_o = chi_i ? lut_i[addr] : (pick_bit(x_i, fb_idx_i) ^ fb_inv_i);

endmodule

// File: rtl/dred_proj_expander.sv
// Two-stage streaming evaluator of f(x) = chi(x) ? f_P(x|sel) : fallback(x).
module dred_proj_expander
  import dred_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  dred_proj_expander_if.slave  bus
);

  logic [LUT_W-1:0] lut_q, lut_d;
  sel_vec_t         sel_q, sel_d;
  logic [N_IN-1:0]  chi_mask_q, chi_mask_d;
  logic [N_IN-1:0]  chi_val_q, chi_val_d;
  logic [IDX_W-1:0] fb_idx_q, fb_idx_d;
  logic             fb_inv_q, fb_inv_d;

  logic             s1_valid_q, s1_valid_d;
  logic [N_IN-1:0]  s1_x_q, s1_x_d;
  logic             s1_chi_q, s1_chi_d;

  logic             out_valid_q, out_valid_d;
  logic             out_y_q, out_y_d;
  logic             out_proj_q, out_proj_d;

  logic stall, out_adv, in_ready, in_fire, cfg_ready, cfg_fire, chi_in, y_eval;

  assign stall     = out_valid_q & ~bus.out_ready;
  assign out_adv   = ~stall;
  // A full S1 behind a stalled output is the only input-side blocker besides config.
  assign in_ready  = ~bus.cfg_we & ~(s1_valid_q & stall);
  assign in_fire   = bus.in_valid & in_ready;
  assign cfg_ready = ~s1_valid_q & ~out_valid_q;
  assign cfg_fire  = bus.cfg_we & cfg_ready;
  assign chi_in    = (bus.in_x & chi_mask_q) == chi_val_q;

  dred_lut_eval u_eval (
    .x_i      (s1_x_q),
    .chi_i    (s1_chi_q),
    .lut_i    (lut_q),
    .sel_i    (sel_q),
    .fb_idx_i (fb_idx_q),
    .fb_inv_i (fb_inv_q),
    .y_o      (y_eval)
  );

  always_comb begin
    lut_d      = lut_q;
    sel_d      = sel_q;
    chi_mask_d = chi_mask_q;
    chi_val_d  = chi_val_q;
    fb_idx_d   = fb_idx_q;
    fb_inv_d   = fb_inv_q;
    if (cfg_fire) begin
      case (cfg_addr_e'(bus.cfg_addr))
        CFG_LUT:      lut_d      = bus.cfg_wdata[LUT_W-1:0];
        CFG_SEL:      sel_d      = sel_vec_t'(bus.cfg_wdata[K*IDX_W-1:0]);
        CFG_CHI_MASK: chi_mask_d = bus.cfg_wdata;
        CFG_CHI_VAL:  chi_val_d  = bus.cfg_wdata;
        CFG_FB: begin
          fb_idx_d = bus.cfg_wdata[IDX_W-1:0];
          fb_inv_d = bus.cfg_wdata[IDX_W];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s1_valid_d  = in_fire | (s1_valid_q & ~out_adv);
    s1_x_d      = s1_x_q;
    s1_chi_d    = s1_chi_q;
    if (in_fire) begin
      s1_x_d   = bus.in_x;
      s1_chi_d = chi_in;
    end
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_proj_d  = out_proj_q;
    if (out_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_y_d    = y_eval;
        out_proj_d = s1_chi_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_q       <= '0;
      sel_q       <= '0;
      chi_mask_q  <= '0;
      chi_val_q   <= '0;
      fb_idx_q    <= '0;
      fb_inv_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_chi_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_y_q     <= 1'b0;
      out_proj_q  <= 1'b0;
    end else begin
      lut_q       <= lut_d;
      sel_q       <= sel_d;
      chi_mask_q  <= chi_mask_d;
      chi_val_q   <= chi_val_d;
      fb_idx_q    <= fb_idx_d;
      fb_inv_q    <= fb_inv_d;
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_chi_q    <= s1_chi_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_proj_q  <= out_proj_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.cfg_ready   = cfg_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_y       = out_y_q;
  assign bus.out_in_proj = out_proj_q;

endmodule

// File: tb/tb_dred_proj_expander.sv
// Bench for dred_proj_expander: directed tables, drain/reset sequences, random scoreboard.
module tb_dred_proj_expander;
  import dred_pkg::*;

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  dred_proj_expander_if bus ();

  dred_proj_expander dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference configuration, tracked from what the bench writes.
  logic [15:0] m_lut;
  int          m_sel [4];
  logic [23:0] m_mask, m_val;
  int          m_fb_idx;
  bit          m_fb_inv;

  typedef struct {
    logic [23:0] x;
    logic        y;
    logic        proj;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic bit xbit(logic [23:0] x, int idx);
    return (idx < 24) ? x[idx] : 1'b0;
  endfunction

  // Returns {proj, y}.
  function automatic logic [1:0] model(logic [23:0] x);
    int addr;
    bit chi;
    bit y;
    chi  = ((x & m_mask) == m_val);
    addr = 0;
    if (chi) begin
      for (int j = 0; j < 4; j++) addr += int'(xbit(x, m_sel[j])) * (1 << j);
      y = m_lut[addr];
    end else begin
      y = xbit(x, m_fb_idx) ^ m_fb_inv;
    end
    return {chi, y};
  endfunction

  task automatic model_clear();
    m_lut = '0; m_mask = '0; m_val = '0; m_fb_idx = 0; m_fb_inv = 0;
    for (int j = 0; j < 4; j++) m_sel[j] = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.in_valid = 0; bus.in_x = '0; bus.out_ready = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [23:0] d);
    int n;
    @(negedge clk);
    bus.cfg_we = 1; bus.cfg_addr = a; bus.cfg_wdata = d;
    n = 0;
    #1;
    while (!bus.cfg_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!bus.cfg_ready) chk("cfg_ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus.cfg_we = 0;
    case (a)
      3'd0: m_lut = d[15:0];
      3'd1: for (int j = 0; j < 4; j++) m_sel[j] = int'((d >> (5 * j)) & 24'h1f);
      3'd2: m_mask = d;
      3'd3: m_val = d;
      3'd4: begin m_fb_idx = int'(d[4:0]); m_fb_inv = d[5]; end
      default: ;
    endcase
  endtask

  task automatic add(input logic [23:0] x, input logic y, input logic p);
    tbl.push_back('{x: x, y: y, proj: p});
  endtask

  // Back-to-back stream, every result checked exactly two cycles after its vector.
  task automatic run_table();
    int n;
    n = tbl.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      bus.out_ready = 1;
      bus.in_valid  = (i < n);
      if (i < n) bus.in_x = tbl[i].x;
      #1;
      if (i < n) chk("tbl_in_ready", bus.in_ready, 1);
      if (i >= 2) begin
        chk($sformatf("tbl_valid[%0d]", i - 2), bus.out_valid, 1);
        chk($sformatf("tbl_y[%0d]", i - 2), bus.out_y, tbl[i-2].y);
        chk($sformatf("tbl_proj[%0d]", i - 2), bus.out_in_proj, tbl[i-2].proj);
      end
    end
    @(negedge clk); #1;
    chk("tbl_drained", bus.out_valid, 0);
  endtask

  task automatic run_random(input int n);
    logic [1:0] exp_q[$];
    logic [1:0] e;
    int sent, cyc;
    bit prev_stall;
    logic pv_y, pv_p;
    sent = 0; cyc = 0; prev_stall = 0; pv_y = 0; pv_p = 0;
    while ((sent < n || exp_q.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_y", bus.out_y, pv_y);
        chk("stall_proj", bus.out_in_proj, pv_p);
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
      bus.in_x      = 24'($urandom);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("rnd_extra_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rnd_y", bus.out_y, e[0]);
          chk("rnd_proj", bus.out_in_proj, e[1]);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_x));
        sent++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      pv_y = bus.out_y;
      pv_p = bus.out_in_proj;
    end
    chk("rnd_all_sent", sent, n);
    chk("rnd_none_lost", exp_q.size(), 0);
    @(negedge clk);
    bus.in_valid = 0; bus.out_ready = 1;
    #1;
    chk("rnd_no_dup", bus.out_valid, 0);
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    #1;
    while (!bus.out_valid && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk(name, bus.out_valid, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [23:0] m;
    do_reset();

    // Reset state and default pure-LUT mode with an all-zero LUT.
    @(negedge clk); #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_cfg_ready", bus.cfg_ready, 1);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_y", bus.out_y, 0);
    chk("rst_out_proj", bus.out_in_proj, 0);
    tbl.delete();
    add(24'hFFFFFF, 1'b0, 1'b1);
    run_table();

    // f = ~(x2 ? x1 : x3) with address bits {x0,x3,x2,x1}.
    cfg_write(CFG_SEL, 24'h000C41);
    cfg_write(CFG_LUT, 24'h004747);
    cfg_write(CFG_CHI_MASK, 24'h000000);
    cfg_write(3'd7, 24'hFFFFFF);
    tbl.delete();
    add(24'h000000, 1'b1, 1'b1);
    add(24'h000002, 1'b1, 1'b1);
    add(24'h000006, 1'b0, 1'b1);
    add(24'h000008, 1'b0, 1'b1);
    add(24'h00000C, 1'b1, 1'b1);
    run_table();

    // Projection guarded by x23, fallback = ~x5.
    cfg_write(CFG_CHI_MASK, 24'h800000);
    cfg_write(CFG_CHI_VAL, 24'h800000);
    cfg_write(CFG_FB, 24'h000025);
    tbl.delete();
    add(24'h000020, 1'b0, 1'b0);
    add(24'h800000, 1'b1, 1'b1);
    add(24'h000000, 1'b1, 1'b0);
    add(24'h800021, 1'b1, 1'b1);
    run_table();

    // Random configurations and traffic under random backpressure.
    for (int r = 0; r < 2; r++) begin
      int a, b;
      a = $urandom_range(0, 23);
      b = $urandom_range(0, 23);
      m = (24'h1 << a) | (24'h1 << b);
      cfg_write(CFG_LUT, 24'($urandom) & 24'h00FFFF);
      cfg_write(CFG_SEL, 24'($urandom) & 24'h0FFFFF);
      cfg_write(CFG_CHI_MASK, m);
      cfg_write(CFG_CHI_VAL, 24'($urandom) & m);
      cfg_write(CFG_FB, (r == 0) ? 24'($urandom_range(0, 63)) : 24'h00001D);
      run_random(500);
    end

    // Config write held against a full, stalled pipeline.
    cfg_write(CFG_CHI_MASK, 24'h0);
    cfg_write(CFG_CHI_VAL, 24'h0);
    cfg_write(CFG_SEL, 24'h0);
    cfg_write(CFG_LUT, 24'h0);
    @(negedge clk);
    bus.out_ready = 0; bus.in_valid = 1; bus.in_x = 24'h000001;
    @(negedge clk);
    bus.in_x = 24'h000002;
    @(negedge clk);
    bus.in_x = 24'h000003;
    bus.cfg_we = 1; bus.cfg_addr = CFG_LUT; bus.cfg_wdata = 24'h00FFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_cfg_ready", bus.cfg_ready, 0);
      chk("hold_out_valid", bus.out_valid, 1);
      @(negedge clk);
    end
    bus.out_ready = 1;
    #1;
    chk("drain_a_y", bus.out_y, 0);
    chk("drain_a_cfg_ready", bus.cfg_ready, 0);
    @(negedge clk); #1;
    chk("drain_b_valid", bus.out_valid, 1);
    chk("drain_b_y", bus.out_y, 0);
    chk("drain_b_cfg_ready", bus.cfg_ready, 0);
    @(negedge clk); #1;
    chk("empty_out_valid", bus.out_valid, 0);
    chk("empty_cfg_ready", bus.cfg_ready, 1);
    chk("empty_in_ready", bus.in_ready, 0);
    @(negedge clk);
    bus.cfg_we = 0;
    m_lut = 16'hFFFF;
    #1;
    chk("post_cfg_in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 0;
    wait_out("new_lut_valid");
    chk("new_lut_y", bus.out_y, 1);
    chk("new_lut_proj", bus.out_in_proj, 1);

    // Asynchronous reset with two vectors in flight.
    @(negedge clk);
    bus.out_ready = 0; bus.in_valid = 1; bus.in_x = 24'h000001;
    @(negedge clk);
    bus.in_x = 24'h000002;
    @(negedge clk);
    bus.in_valid = 0;
    #1;
    chk("pre_rst_full", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", bus.out_valid, 0);
    chk("rst_async_cfg_ready", bus.cfg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    bus.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_no_stale", bus.out_valid, 0);
    end
    tbl.delete();
    add(24'hFFFFFF, 1'b0, 1'b1);
    add(24'h000001, 1'b0, 1'b1);
    run_table();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
